uart_mmio_fifo: RTL and testbench

//  Memory-mapped UART peripheral with parametrised frame format and TX/RX FIFOs; successor to the single-byte UART on the core's data bus.

---
 rtl/uart_mmio_fifo.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_uart_mmio_fifo.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART with runtime baud divisor, optional parity, TX/RX FIFOs,
// sticky error flags and a level interrupt. Four 32-bit registers on addr[3:2]:
// TXDATA (push), RXDATA (pop), STATUS (W1C flags), CTRL (divisor/parity/irq enables).
module uart_mmio_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 868,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // Divisors below 2 would collapse the half-bit wait to zero, so clamp them.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < 16'd2) ? 16'd2 : d;
  endfunction

  function automatic logic par_of(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  logic       wr_en, rd_en;
  logic [1:0] reg_sel;
  logic       unused_bits;
  assign wr_en       = sel & we;
  assign rd_en       = sel & re;
  assign reg_sel     = addr[3:2];
  assign unused_bits = ^{addr[1:0], wdata[31:20]};

  // Control register fields
  logic [15:0] div_q;
  logic        par_en_q, par_odd_q, rx_ie_q, tx_ie_q;
  // Sticky flags
  logic        ovr_q, ferr_q, perr_q, drop_q;

  // TX FIFO
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic [CW-1:0]        tx_cnt;
  logic                 tx_full, tx_empty, tx_push, tx_pop, tx_drop_set;
  // RX FIFO
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wp, rx_rp;
  logic [CW-1:0]        rx_cnt;
  logic                 rx_full, rx_empty, rx_push, rx_pop, rx_ovr_set;

  // TX engine
  state_t               tx_state, tx_state_nx;
  logic [15:0]          tx_tmr, tx_div;
  logic [3:0]           tx_bit;
  logic                 tx_stop_n, tx_par_en, tx_parbit, tx_tick, tx_busy;
  logic [DATA_BITS-1:0] tx_shift;
  // RX engine
  logic                 rx_meta, rx_sync;
  state_t               rx_state, rx_state_nx;
  logic [15:0]          rx_tmr, rx_div;
  logic [3:0]           rx_bit;
  logic                 rx_par_en, rx_par_odd, rx_parbit, rx_tick, rx_start, rx_push_req;
  logic                 ferr_set, perr_set;
  logic [DATA_BITS-1:0] rx_shift;

  logic [31:0] status, ctrl_rd, rd_val;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign tx_busy  = (tx_state != S_IDLE);

  // A push into a full FIFO still lands when a pop frees a slot in the same cycle.
  assign tx_push     = wr_en && (reg_sel == 2'd0) && (!tx_full || tx_pop);
  assign tx_drop_set = wr_en && (reg_sel == 2'd0) && tx_full && !tx_pop;
  assign rx_pop      = rd_en && (reg_sel == 2'd1) && !rx_empty;
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign rx_ovr_set  = rx_push_req && rx_full && !rx_pop;
  assign ferr_set    = rx_push_req && !rx_sync;
  assign perr_set    = rx_push_req && rx_par_en && (rx_parbit != par_of(rx_shift, rx_par_odd));

  assign status  = {23'd0, drop_q, tx_busy, perr_q, ferr_q, ovr_q,
                    rx_full, rx_empty, tx_empty, tx_full};
  assign ctrl_rd = {12'd0, tx_ie_q, rx_ie_q, par_odd_q, par_en_q, div_q};
  assign irq     = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty & ~tx_busy);

  // Read mux built from pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = 32'd0;
    case (reg_sel)
      2'd1:    rd_val = rx_empty ? 32'h8000_0000 : 32'(rx_mem[rx_rp]);
      2'd2:    rd_val = status;
      2'd3:    rd_val = ctrl_rd;
      default: rd_val = 32'd0;
    endcase
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     rdata <= 32'd0;
    else if (rd_en) rdata <= rd_val;
  end

  // CTRL register and sticky STATUS flags (a new event wins over a same-cycle clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= 16'(DIV_RESET);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      rx_ie_q   <= 1'b0;
      tx_ie_q   <= 1'b0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      if (wr_en && reg_sel == 2'd3) begin
        div_q     <= wdata[15:0];
        par_en_q  <= wdata[16];
        par_odd_q <= wdata[17];
        rx_ie_q   <= wdata[18];
        tx_ie_q   <= wdata[19];
      end
      ovr_q  <= rx_ovr_set  | (ovr_q  & ~(wr_en && reg_sel == 2'd2 && wdata[4]));
      ferr_q <= ferr_set    | (ferr_q & ~(wr_en && reg_sel == 2'd2 && wdata[5]));
      perr_q <= perr_set    | (perr_q & ~(wr_en && reg_sel == 2'd2 && wdata[6]));
      drop_q <= tx_drop_set | (drop_q & ~(wr_en && reg_sel == 2'd2 && wdata[8]));
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  // FIFO storage (data only, no reset).
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[DATA_BITS-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  // TX next-state: pop at IDLE, or straight from the last STOP cycle for gapless frames.
  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    tx_tick     = (tx_tmr == 16'd0);
    case (tx_state)
      S_IDLE:  if (!tx_empty) begin
                 tx_pop      = 1'b1;
                 tx_state_nx = S_START;
               end
      S_START: if (tx_tick) tx_state_nx = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == LAST_BIT) tx_state_nx = tx_par_en ? S_PAR : S_STOP;
      S_PAR:   if (tx_tick) tx_state_nx = S_STOP;
      S_STOP:  if (tx_tick && tx_stop_n == LAST_STOP) begin
                 if (!tx_empty) begin
                   tx_pop      = 1'b1;
                   tx_state_nx = S_START;
                 end else begin
                   tx_state_nx = S_IDLE;
                 end
               end
      default: tx_state_nx = S_IDLE;
    endcase
  end

  // TX state, bit timer and counters; divisor and parity enable latched per frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state  <= S_IDLE;
      tx_tmr    <= 16'd0;
      tx_div    <= 16'd2;
      tx_bit    <= 4'd0;
      tx_stop_n <= 1'b0;
      tx_par_en <= 1'b0;
    end else begin
      tx_state <= tx_state_nx;
      if (tx_pop) begin
        tx_tmr    <= eff_div(div_q) - 16'd1;
        tx_div    <= eff_div(div_q);
        tx_par_en <= par_en_q;
        tx_bit    <= 4'd0;
        tx_stop_n <= 1'b0;
      end else if (tx_state != S_IDLE) begin
        if (tx_tick) begin
          tx_tmr <= tx_div - 16'd1;
          if (tx_state == S_DATA) tx_bit <= tx_bit + 4'd1;
          if (tx_state == S_STOP) tx_stop_n <= tx_stop_n + 1'b1;
        end else begin
          tx_tmr <= tx_tmr - 16'd1;
        end
      end
    end
  end

  // TX shift register and parity bit, loaded on pop, shifted LSB first.
  always_ff @(posedge clk) begin
    if (tx_pop) begin
      tx_shift  <= tx_mem[tx_rp];
      tx_parbit <= par_of(tx_mem[tx_rp], par_odd_q);
    end else if (tx_state == S_DATA && tx_tick) begin
      tx_shift <= tx_shift >> 1;
    end
  end

  // Serial line driven from state so reset forces it high immediately.
  always_comb begin
    tx = 1'b1;
    case (tx_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_shift[0];
      S_PAR:   tx = tx_parbit;
      default: tx = 1'b1;
    endcase
  end

  // Two-flop synchroniser on the asynchronous serial input, idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // RX next-state: half-bit start qualification, then centre sampling.
  always_comb begin
    rx_state_nx = rx_state;
    rx_start    = 1'b0;
    rx_push_req = 1'b0;
    rx_tick     = (rx_tmr == 16'd0);
    case (rx_state)
      S_IDLE:  if (!rx_sync) begin
                 rx_start    = 1'b1;
                 rx_state_nx = S_START;
               end
      S_START: if (rx_tick) rx_state_nx = rx_sync ? S_IDLE : S_DATA;
      S_DATA:  if (rx_tick && rx_bit == LAST_BIT) rx_state_nx = rx_par_en ? S_PAR : S_STOP;
      S_PAR:   if (rx_tick) rx_state_nx = S_STOP;
      S_STOP:  if (rx_tick) begin
                 rx_push_req = 1'b1;
                 rx_state_nx = S_IDLE;
               end
      default: rx_state_nx = S_IDLE;
    endcase
  end

  // RX state, bit timer and bit counter; frame format latched at start detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state   <= S_IDLE;
      rx_tmr     <= 16'd0;
      rx_div     <= 16'd2;
      rx_bit     <= 4'd0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      if (rx_start) begin
        rx_tmr     <= (eff_div(div_q) >> 1) - 16'd1;
        rx_div     <= eff_div(div_q);
        rx_par_en  <= par_en_q;
        rx_par_odd <= par_odd_q;
        rx_bit     <= 4'd0;
      end else if (rx_state != S_IDLE) begin
        if (rx_tick) begin
          rx_tmr <= rx_div - 16'd1;
          if (rx_state == S_DATA) rx_bit <= rx_bit + 4'd1;
        end else begin
          rx_tmr <= rx_tmr - 16'd1;
        end
      end
    end
  end

  // RX data capture: shift in from the top so the first bit ends up as LSB.
  always_ff @(posedge clk) begin
    if (rx_state == S_DATA && rx_tick) rx_shift  <= {rx_sync, rx_shift[DATA_BITS-1:1]};
    if (rx_state == S_PAR && rx_tick)  rx_parbit <= rx_sync;
  end

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: register access table, TX waveform,
// TX FIFO fill/drop, loopback with parity, RX error cases, RX overrun, reset mid-frame.
module tb_uart_mmio_fifo;

  logic        clk, reset, sel, we, re, rx, tx, irq;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata;
  logic        rx_drv, loop_en;

  int n_tests = 0;
  int n_fail  = 0;

  logic txlog [0:1023];
  int   rec_idx = 0;
  bit   rec_en  = 0;

  uart_mmio_fifo dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb rx = loop_en ? tx : rx_drv;

  always @(negedge clk) begin
    if (rec_en && rec_idx < 1024) begin
      txlog[rec_idx] = tx;
      rec_idx++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t vt [0:13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    d = rdata;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_en, input bit par_val,
                            input bit stop_val, input int div);
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (div) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      rx_drv = d[j];
      repeat (div) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = par_val;
      repeat (div) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (div) @(negedge clk);
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    logic [9:0]  fr;
    int          k, s;
    bit          all_idle;

    vt[0]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0006, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0000_0364, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h8000_0000, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4'hC, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[4]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h000F_FFFF, 1'b1};
    vt[5]  = '{1'b1, 1'b0, 4'h8, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0006, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 4'h4, 32'h0000_0055, 32'h0000_0006, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0006, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 4'hC, 32'h0008_0004, 32'h000F_FFFF, 1'b1};
    vt[10] = '{1'b0, 1'b1, 4'hF, 32'h0,         32'h0008_0004, 1'b1};
    vt[11] = '{1'b0, 1'b0, 4'h0, 32'h0,         32'h0008_0004, 1'b1};
    vt[12] = '{1'b1, 1'b0, 4'hC, 32'h0000_0004, 32'h0008_0004, 1'b0};
    vt[13] = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0000_0004, 1'b0};

    sel = 0; we = 0; re = 0; addr = 0; wdata = 0; rx_drv = 1; loop_en = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset irq", {31'd0, irq}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    reset = 1'b1;

    // Register access table
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sel = vt[i].we | vt[i].re; we = vt[i].we; re = vt[i].re;
      addr = vt[i].addr; wdata = vt[i].wdata;
      @(negedge clk);
      sel = 0; we = 0; re = 0;
      chk($sformatf("vec%0d rdata", i), rdata, vt[i].exp_rdata);
      chk($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
    end

    // Single 0xA5 frame at DIV=4, 8N1
    bus_write(4'h0, 32'hA5);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    fr = {1'b1, 8'hA5, 1'b0};
    for (int bi = 0; bi < 10; bi++)
      for (int c = 0; c < 4; c++) begin
        if (bi != 0 || c != 0) @(negedge clk);
        chk($sformatf("txA5 bit%0d cyc%0d", bi, c), {31'd0, tx}, {31'd0, fr[bi]});
      end
    bus_read(4'h8, rd);
    chk("txA5 status after", rd, 32'h0000_0006);

    // 17 back-to-back pushes, then one more into a full FIFO
    @(negedge clk);
    rec_idx = 0; rec_en = 1;
    sel = 1; we = 1; addr = 4'h0;
    for (int i = 0; i < 17; i++) begin
      wdata = 32'h10 + i;
      @(negedge clk);
    end
    sel = 0; we = 0;
    bus_read(4'h8, rd);
    chk("burst status full", rd, 32'h0000_0085);
    bus_write(4'h0, 32'hEE);
    bus_read(4'h8, rd);
    chk("burst status drop", rd, 32'h0000_0185);
    repeat (700) @(negedge clk);
    rec_en = 0;
    s = 0;
    while (s < 100 && txlog[s] !== 1'b0) s++;
    chk("burst first start", (s < 100) ? 32'd1 : 32'd0, 32'd1);
    if (s >= 100) s = 0;
    for (int f = 0; f < 17; f++) begin
      k = s + 40 * f;
      for (int j = 0; j < 8; j++) b[j] = txlog[k + 4 * (j + 1) + 2];
      chk($sformatf("burst frame%0d data", f), {24'd0, b}, 32'h10 + f);
      chk($sformatf("burst frame%0d start/stop", f),
          {29'd0, (f == 0) ? 1'b1 : txlog[k - 1], txlog[k], txlog[k + 38]}, 32'h5);
    end
    all_idle = 1;
    for (int j = 0; j < 20; j++) if (txlog[s + 680 + j] !== 1'b1) all_idle = 0;
    chk("burst idle after 17", {31'd0, all_idle}, 32'd1);
    bus_write(4'h8, 32'h100);
    bus_read(4'h8, rd);
    chk("tx_drop w1c", rd, 32'h0000_0006);

    // Loopback, odd parity, 0x3C
    bus_write(4'hC, 32'h0003_0004);
    loop_en = 1;
    bus_write(4'h0, 32'h3C);
    repeat (80) @(negedge clk);
    bus_read(4'h8, rd);
    chk("loop status", rd, 32'h0000_0002);
    bus_read(4'h4, rd);
    chk("loop rxdata", rd, 32'h0000_003C);
    loop_en = 0;
    bus_read(4'h8, rd);
    chk("loop status empty", rd, 32'h0000_0006);

    // Wrong parity bit (odd parity on 0x3C needs 1; send 0)
    bus_write(4'hC, 32'h0003_0008);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8);
    repeat (20) @(negedge clk);
    bus_read(4'h8, rd);
    chk("perr status", rd, 32'h0000_0042);
    bus_read(4'h4, rd);
    chk("perr rxdata", rd, 32'h0000_003C);
    bus_write(4'h8, 32'h40);
    bus_read(4'h8, rd);
    chk("perr w1c", rd, 32'h0000_0006);

    // One-cycle glitch at DIV=8 is a false start
    bus_write(4'hC, 32'h0000_0008);
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (30) @(negedge clk);
    bus_read(4'h8, rd);
    chk("glitch status", rd, 32'h0000_0006);

    // Stop bit low -> frame error, byte still pushed
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8);
    repeat (20) @(negedge clk);
    bus_read(4'h8, rd);
    chk("ferr status", rd, 32'h0000_0022);
    bus_read(4'h4, rd);
    chk("ferr rxdata", rd, 32'h0000_005A);
    bus_write(4'h8, 32'h20);
    bus_read(4'h8, rd);
    chk("ferr w1c", rd, 32'h0000_0006);

    // 17 frames without reading -> full + overrun
    for (int i = 0; i < 17; i++) send_frame(8'hC0 + 8'(i), 1'b0, 1'b0, 1'b1, 8);
    repeat (20) @(negedge clk);
    bus_read(4'h8, rd);
    chk("ovr status", rd, 32'h0000_001A);
    for (int i = 0; i < 16; i++) begin
      bus_read(4'h4, rd);
      chk($sformatf("ovr rxdata%0d", i), rd, 32'hC0 + i);
    end
    bus_read(4'h4, rd);
    chk("rx read empty", rd, 32'h8000_0000);
    bus_read(4'h8, rd);
    chk("ovr status drained", rd, 32'h0000_0016);
    bus_write(4'h8, 32'h10);
    bus_read(4'h8, rd);
    chk("ovr w1c", rd, 32'h0000_0006);

    // Reset in the middle of a TX data bit
    bus_write(4'hC, 32'h0008_0004);
    chk("tx irq idle", {31'd0, irq}, 32'd1);
    bus_read(4'hC, rd);
    chk("ctrl before reset", rd, 32'h0008_0004);
    bus_write(4'h0, 32'hA5);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin @(negedge clk); k++; end
    repeat (9) @(negedge clk);
    chk("tx mid data bit", {31'd0, tx}, 32'd0);
    chk("irq while busy", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    #1;
    chk("async reset tx", {31'd0, tx}, 32'd1);
    chk("async reset irq", {31'd0, irq}, 32'd0);
    chk("async reset rdata", rdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus_read(4'h8, rd);
    chk("status after reset", rd, 32'h0000_0006);
    bus_read(4'hC, rd);
    chk("ctrl after reset", rd, 32'h0000_0364);
    repeat (20) @(negedge clk);
    chk("tx idle after reset", {31'd0, tx}, 32'd1);
    chk("irq after reset", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
